// File: rtl/edl_pwm_pkg.sv
// -----------------------------------------------------------------------------
// edl_pwm_pkg
// Shared definitions for the PWM generator slice:
//   - pwm_state_e      : FSM state encoding (IDLE, RUN)
//   - CNT_W            : width of the prescaler, period counter and duty value
//   - DEFAULT_PRESCALE : default clk cycles per count tick
//   - DEFAULT_PERIOD   : default count ticks per PWM period
// -----------------------------------------------------------------------------
package edl_pwm_pkg;

   localparam int CNT_W            = 16;
   localparam int DEFAULT_PRESCALE = 50;
   localparam int DEFAULT_PERIOD   = 1000;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } pwm_state_e;

endpackage

// File: rtl/edl_pwm_prescaler.sv
// -----------------------------------------------------------------------------
// edl_pwm_prescaler
// Divides clk down to a one-cycle count tick every PRESCALE clk cycles.
//
// Ports:
//   clk     in  clock, rising edge
//   reset_n in  asynchronous active-low reset
//   clr     in  synchronous clear; the divider holds 0 while clr is high
//   run     in  advance the divider; tick is only produced while run is high
//   tick    out high in the cycle the divider sits at PRESCALE-1
//
// Legal PRESCALE range is 1..65535. With PRESCALE = 1 the divider stays at 0
// and tick is high in every run cycle.
// -----------------------------------------------------------------------------
module edl_pwm_prescaler
   import edl_pwm_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic run,
   output logic tick
);

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] presc_q;
   logic [CNT_W-1:0] presc_d;

   always_comb begin
      presc_d = presc_q;
      if (clr) begin
         presc_d = '0;
      end else if (run) begin
         presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   assign tick = run && (presc_q == PRESC_LAST);

endmodule

// File: rtl/edl_pwm_gen.sv
// -----------------------------------------------------------------------------
// edl_pwm_gen
// Prescaled PWM generator with a per-period duty shadow register.
//
// Parameters:
//   PRESCALE  clk cycles per count tick, 1..65535
//   PERIOD    count ticks per PWM period, 2..65535
//
// Ports:
//   clk           in  clock, rising edge
//   reset_n       in  asynchronous active-low reset
//   enable        in  run request
//   duty_in [15:0] in requested high time in ticks (CPU PIO, unsynchronised,
//                     only ever sampled into duty_shadow)
//   pwm_out       out registered PWM waveform
//   period_start  out registered one-cycle pulse in the cycle cnt becomes 0
//   count_out[15:0] out current period count
//
// All outputs come straight from flops, so there is no input-to-output
// combinational path. pwm_out and period_start are computed from the next
// cnt/duty_shadow values so that they line up with count_out in the same cycle.
// -----------------------------------------------------------------------------
module edl_pwm_gen
   import edl_pwm_pkg::*;
#(
   parameter int PRESCALE = DEFAULT_PRESCALE,
   parameter int PERIOD   = DEFAULT_PERIOD
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [CNT_W-1:0] duty_in,
   output logic             pwm_out,
   output logic             period_start,
   output logic [CNT_W-1:0] count_out
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

   pwm_state_e       state_q;
   pwm_state_e       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] duty_shadow_q;
   logic [CNT_W-1:0] duty_shadow_d;
   logic             pwm_q;
   logic             pwm_d;
   logic             period_start_q;
   logic             period_start_d;

   logic             tick;
   logic             presc_clr;
   logic             presc_run;

   // Divider only advances while we stay in RUN; any cycle that leaves or
   // enters RUN (or idles) parks it at 0 so the next period starts clean.
   assign presc_run = (state_q == ST_RUN);
   assign presc_clr = !((state_q == ST_RUN) && (state_d == ST_RUN));

   edl_pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (presc_clr),
      .run     (presc_run),
      .tick    (tick)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (enable)  state_d = ST_RUN;
         ST_RUN:  if (!enable) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath logic. Default is the IDLE picture: counter cleared,
   // outputs low, shadow tracking duty_in every clk.
   always_comb begin
      cnt_d          = '0;
      duty_shadow_d  = duty_in;
      period_start_d = 1'b0;

      if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
         cnt_d         = cnt_q;
         duty_shadow_d = duty_shadow_q;
         if (tick) begin
            if (cnt_q == CNT_LAST) begin
               // Wrap: the new duty value takes effect at cnt 0 of the new
               // period because pwm_d below uses the updated shadow.
               cnt_d          = '0;
               duty_shadow_d  = duty_in;
               period_start_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end else if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
         period_start_d = 1'b1;
      end

      pwm_d = (state_d == ST_RUN) && (cnt_d < duty_shadow_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q          <= '0;
         duty_shadow_q  <= '0;
         pwm_q          <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         cnt_q          <= cnt_d;
         duty_shadow_q  <= duty_shadow_d;
         pwm_q          <= pwm_d;
         period_start_q <= period_start_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;
   assign count_out    = cnt_q;

endmodule

// File: tb/tb_edl_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_edl_pwm_gen
// Two instances: dut_a (PRESCALE=1, PERIOD=10) and dut_b (PRESCALE=4,
// PERIOD=10). A model tracks, per instance, whether it is running, the clk
// cycles elapsed inside the current period and the latched duty; every output
// follows from those with plain arithmetic. Directed phases add literal
// expectations for the waveform shapes.
// -----------------------------------------------------------------------------
module tb_edl_pwm_gen;

   localparam int PS_A = 1;
   localparam int PS_B = 4;
   localparam int PD   = 10;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        en;
   logic [1:0][15:0]  duty;
   logic [1:0]        pwm;
   logic [1:0]        ps;
   logic [1:0][15:0]  cnt_o;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   edl_pwm_gen #(.PRESCALE(PS_A), .PERIOD(PD)) dut_a (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (en[0]),
      .duty_in      (duty[0]),
      .pwm_out      (pwm[0]),
      .period_start (ps[0]),
      .count_out    (cnt_o[0])
   );

   edl_pwm_gen #(.PRESCALE(PS_B), .PERIOD(PD)) dut_b (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (en[1]),
      .duty_in      (duty[1]),
      .pwm_out      (pwm[1]),
      .period_start (ps[1]),
      .count_out    (cnt_o[1])
   );

   function automatic int ps_of(input int i);
      return (i == 0) ? PS_A : PS_B;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   bit          run_m [2] = '{1'b0, 1'b0};
   int          el_m  [2] = '{0, 0};
   logic [15:0] sh_m  [2] = '{16'd0, 16'd0};

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            run_m[i] <= 1'b0;
            el_m[i]  <= 0;
            sh_m[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (run_m[i] && en[i]) begin
               el_m[i] <= (el_m[i] + 1) % (ps_of(i) * PD);
               if ((el_m[i] + 1) % (ps_of(i) * PD) == 0) sh_m[i] <= duty[i];
            end else begin
               run_m[i] <= en[i];
               el_m[i]  <= 0;
               sh_m[i]  <= duty[i];
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 2; i++) begin
            int ce;
            ce = run_m[i] ? el_m[i] / ps_of(i) : 0;
            check($sformatf("model_cnt[%0d]", i), int'(cnt_o[i]), ce);
            check($sformatf("model_pwm[%0d]", i), int'(pwm[i]),
                  (run_m[i] && (ce < int'(sh_m[i]))) ? 1 : 0);
            check($sformatf("model_ps[%0d]", i), int'(ps[i]),
                  (run_m[i] && el_m[i] == 0) ? 1 : 0);
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic wait_cnt(input int i, input int val, input int lim);
      int n = 0;
      while (int'(cnt_o[i]) != val && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("wait_cnt", int'(cnt_o[i]), val);
   endtask

   task automatic wait_ps(input int i, input int lim);
      int n = 0;
      while (ps[i] != 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      check("wait_ps", int'(ps[i]), 1);
   endtask

   // counts high cycles of pwm and period_start over n cycles
   task automatic count_hi(input int i, input int n, output int hi, output int pss);
      hi  = 0;
      pss = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         hi  += int'(pwm[i]);
         pss += int'(ps[i]);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [19:0] pat;
      logic [19:0] psp;
      logic [13:0] pat2;
      int hi, pss;

      reset_n = 1'b0;
      en      = '0;
      duty    = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("reset_pwm", int'(pwm[i]), 0);
         check("reset_ps", int'(ps[i]), 0);
         check("reset_cnt", int'(cnt_o[i]), 0);
      end
      chk_on  = 1'b1;
      reset_n = 1'b1;
      @(negedge clk);

      // duty 3 on PRESCALE=1: 3 high, 7 low, period_start on first high cycle
      duty[0] = 16'd3;
      en[0]   = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         pat[k] = pwm[0];
         psp[k] = ps[0];
      end
      check("pwm_pattern_d3", int'(pat), 20'h01C07);
      check("ps_pattern_d3", int'(psp), 20'h00401);

      // duty change mid-period: current period unaffected, next gets 7 high
      wait_cnt(0, 5, 20);
      duty[0] = 16'd7;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         pat2[k] = pwm[0];
      end
      check("pwm_pattern_d7", int'(pat2), 14'h07F0);

      // duty 0: never high, period_start still every 10
      duty[0] = 16'd0;
      repeat (12) @(negedge clk);
      count_hi(0, 30, hi, pss);
      check("d0_high", hi, 0);
      check("d0_ps", pss, 3);

      // duty = PERIOD and 0xFFFF: continuously high across wraps
      duty[0] = 16'd10;
      repeat (12) @(negedge clk);
      count_hi(0, 30, hi, pss);
      check("d10_high", hi, 30);
      check("d10_ps", pss, 3);
      duty[0] = 16'hFFFF;
      repeat (12) @(negedge clk);
      count_hi(0, 30, hi, pss);
      check("dffff_high", hi, 30);

      // PRESCALE=4, duty 2: 8 high then 32 low, count steps every 4 clks
      duty[1] = 16'd2;
      en[1]   = 1'b1;
      hi  = 0;
      pss = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         hi  += int'(pwm[1]);
         pss += int'(ps[1]);
         if (k == 7)  check("b_high_first8", hi, 8);
         if (k == 3)  check("b_cnt_at3", int'(cnt_o[1]), 0);
         if (k == 4)  check("b_cnt_at4", int'(cnt_o[1]), 1);
         if (k == 39) check("b_cnt_at39", int'(cnt_o[1]), 9);
      end
      check("b_high_total", hi, 8);
      check("b_ps_total", pss, 1);

      // enable dropped at cnt=1 while high, then re-enabled
      duty[0] = 16'd3;
      wait_ps(0, 25);
      @(negedge clk);
      check("drop_pre_cnt", int'(cnt_o[0]), 1);
      check("drop_pre_pwm", int'(pwm[0]), 1);
      en[0] = 1'b0;
      @(negedge clk);
      check("drop_pwm", int'(pwm[0]), 0);
      check("drop_cnt", int'(cnt_o[0]), 0);
      check("drop_ps", int'(ps[0]), 0);
      en[0] = 1'b1;
      @(negedge clk);
      check("reen_ps", int'(ps[0]), 1);
      check("reen_cnt", int'(cnt_o[0]), 0);
      check("reen_pwm", int'(pwm[0]), 1);

      // asynchronous reset in the middle of the high time
      @(negedge clk);
      @(posedge clk);
      #2;
      check("pre_rst_pwm", int'(pwm[0]), 1);
      reset_n = 1'b0;
      #1;
      check("arst_pwm", int'(pwm[0]), 0);
      check("arst_ps", int'(ps[0]), 0);
      check("arst_cnt", int'(cnt_o[0]), 0);
      check("arst_cnt_b", int'(cnt_o[1]), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rel_ps", int'(ps[0]), 1);
      check("rel_cnt", int'(cnt_o[0]), 0);
      check("rel_pwm", int'(pwm[0]), 1);
      check("rel_ps_b", int'(ps[1]), 1);
      repeat (45) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/edl_pwm_gen.md
EDL_PWM_GEN -- requirements
Module: edl_pwm_gen

Interface
REQ-001 SHALL have parameter PRESCALE, default 50: clk cycles per count tick; legal range 1..65535.
REQ-002 SHALL have parameter PERIOD, default 1000: count ticks per PWM period; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  run request, clk domain.
REQ-006 SHALL have port duty_in  input  16  requested high-time in ticks; driven directly by the CPU duty-register PIO out_port, clk domain, no synchroniser.
REQ-007 SHALL have port pwm_out  output  1  registered PWM waveform.
REQ-008 SHALL have port period_start  output  1  registered one-cycle pulse marking count 0 of each period.
REQ-009 SHALL have port count_out  output  16  current period count, for debug/readback.

Function
REQ-010 SHALL implement a two-state FSM: IDLE and RUN.
REQ-011 IDLE: prescaler = 0, cnt = 0, pwm_out = 0, period_start = 0, duty_shadow loaded from duty_in every clk.
REQ-012 IDLE -> RUN when enable = 1 at a clk edge; in the following cycle cnt = 0, prescaler = 0, duty_shadow = duty_in sampled at that edge, period_start = 1.
REQ-013 RUN -> IDLE when enable = 0 at a clk edge; IDLE values of REQ-011 visible in the following cycle, mid-period included.
REQ-014 RUN: prescaler counts 0..PRESCALE-1 and wraps; tick asserted in the cycle prescaler = PRESCALE-1.
REQ-015 RUN: cnt advances by 1 on each tick, wrapping from PERIOD-1 to 0; no other cnt change in RUN.
REQ-016 duty_shadow SHALL load duty_in only on the tick that wraps cnt to 0 (and per REQ-011/012); a duty_in change mid-period does not affect the current period.
REQ-017 pwm_out SHALL equal 1 in exactly those cycles where state = RUN and cnt < duty_shadow (unsigned 16-bit compare); computed from next-state values so the output register aligns with cnt.
REQ-018 duty_shadow = 0: pwm_out constantly 0; duty_shadow >= PERIOD: pwm_out constantly 1 with no low glitch at wrap.
REQ-019 period_start SHALL be 1 for exactly one clk in the cycle cnt becomes 0 via wrap or via REQ-012; otherwise 0.
REQ-020 count_out SHALL equal cnt.
REQ-021 Duty change applied at a wrap SHALL take effect at cnt = 0 of the new period without a one-cycle glitch.
REQ-022 PRESCALE = 1: tick every clk; period = PERIOD clk cycles exactly.

Reset
REQ-023 reset_n low SHALL asynchronously force state = IDLE, prescaler = 0, cnt = 0, duty_shadow = 0, pwm_out = 0, period_start = 0.
REQ-024 Reset deassertion SHALL take effect on a clk edge; first RUN entry follows REQ-012 only.
REQ-025 Reset asserted mid-period SHALL drop pwm_out to 0 immediately, without waiting for clk.

Structure
REQ-026 Shared package edl_pwm_pkg SHALL hold the FSM state encoding (IDLE, RUN), the counter width constant (16), and default PRESCALE/PERIOD constants.
REQ-027 Prescaler SHALL be a sub-module edl_pwm_prescaler (inputs clk, reset_n, clr, run; output tick); the period counter, shadow and compare stay in the top.
REQ-028 No combinational path from any input to any output.

Verification
REQ-029 PRESCALE=1, PERIOD=10, duty_in=3, enable rises -> pwm_out 3 cycles high, 7 low, repeating; period_start every 10 clks aligned with first high cycle.
REQ-030 Same setup, duty_in 3 -> 7 at cnt=5 -> current period 3 high; next period 7 high, 3 low; no glitch at the wrap.
REQ-031 duty_in=0 -> pwm_out 0 forever, period_start still every 10 clks; duty_in=10 and 16'hFFFF -> pwm_out 1 continuously across wraps.
REQ-032 PRESCALE=4, PERIOD=10, duty_in=2 -> 8 clks high, 32 low per 40-clk period; count_out steps every 4 clks, 0..9.
REQ-033 enable dropped at cnt=1 while pwm_out=1 -> next cycle pwm_out=0, count_out=0; re-enable -> period_start pulse and fresh period from cnt 0.
REQ-034 reset_n pulsed low asynchronously mid-high-time -> pwm_out, period_start, count_out 0 before next clk edge; after release with enable=1, REQ-012 sequence observed.
